rgb_stream_remap: RTL and testbench
===================================

# rgb_stream_remap

Parametrised pixel-stream colour expander between the frame-buffer/pixel-generator side (packed low-depth RGB, default RGB332) and the board video DAC pins (default 4 bits per channel). It generalises the fixed RGB332→RGB444 zero-pad mapping to arbitrary channel widths and adds run-time selectable expansion modes. Mode changes are frame-synchronous. It also provides a registered valid/ready pipeline with a one-beat skid buffer and carries sync sideband signals with the same latency as the pixel data.

## Interface
- R_IN_W, default 3: input red width. Legal range is 1..OUT_W.
- G_IN_W, default 3: input green width. Legal range is 1..OUT_W.
- B_IN_W, default 2: input blue width. Legal range is 1..OUT_W.
- OUT_W, default 4: output width per channel. Legal range is 1..8. An out-of-range parameter is an elaboration error.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mode  in  2  requested expansion mode: 0 ZERO_PAD, 1 SHIFT, 2 REPLICATE, 3 BLANK.
- in_pixel  in  R_IN_W+G_IN_W+B_IN_W  packed {R,G,B}, R at the MSBs (default R[7:5], G[4:2], B[1:0]).
- in_hsync, in_vsync, in_de  in  1 each  sideband; passed through unchanged.
- in_sof  in  1  first beat of a frame.
- in_valid  in  1 / in_ready  out  1  input handshake.
- R, G, B  out  OUT_W each  expanded colour channels.
- out_hsync, out_vsync, out_de, out_sof  out  1 each  delayed sideband.
- out_valid  out  1 / out_ready  in  1  output handshake.

## Operation
- A beat is accepted on an edge where in_valid && in_ready. A beat is consumed on an edge where out_valid && out_ready.
- Active mode register: reset value 0. It loads `mode` only on an accepted beat with in_sof=1, and the new mode applies to that same beat. A `mode` change at any other time is ignored until the next accepted in_sof beat.
- Conversion happens at acceptance. Beats already in the skid or output register keep the mode they were converted with.
- Per-channel rule, for input width W and value v:
  - ZERO_PAD: zero-extend v to OUT_W. This is the legacy behaviour.
  - SHIFT: v << (OUT_W−W); low bits are 0.
  - REPLICATE: concatenate v repeatedly MSB-first and keep the top OUT_W bits.
  - BLANK: all channel outputs are 0.
  - W = OUT_W: ZERO_PAD, SHIFT and REPLICATE all pass v through unchanged.
- in_de=0 forces R/G/B=0 in every mode. Sideband is never modified.
- Storage is an output register plus one skid register. Each holds {R,G,B,hsync,vsync,de,sof}.
- in_ready is registered and equals "skid empty".
- An accept while the output register is empty, or being consumed, loads the output register. An accept while the output is held (out_valid && !out_ready) loads the skid.
- When the output is consumed and the skid is full, the skid moves to the output register and the skid empties.
- Beats are never lost, duplicated or reordered.

## Timing
- Latency is 1 cycle: a beat accepted at edge k drives out_valid=1 and its data after edge k, provided the output was empty or consumed at edge k.
- Full throughput is 1 beat/cycle while out_ready=1.
- Stall: the first held cycle still accepts one beat into the skid. in_ready falls after that edge.
- Release: the edge where out_ready=1 moves the skid to the output. in_ready rises after that same edge.
- Output data and sideband are stable while out_valid && !out_ready.
- Reset (async assert, mid-stream included):
  - out_valid=0, in_ready=0, R/G/B=0, out_hsync/vsync/de/sof=0, skid empty, active mode=0.
  - All in-flight beats are discarded.
  - in_ready rises on the first clk edge after rst_n deasserts.

## Test plan
- Mode 0 with in_pixel=8'b101_011_10 and in_de=1 → R=4'b0101, G=4'b0011, B=4'b0010 one cycle later. Mode 1 on the same pixel → R=1010, G=0110, B=1000. Mode 2 → R=1011, G=0110, B=1010. Mode 3 → all 0, with sideband intact.
- Mode change mid-frame (mode 0→2 without in_sof) → conversion stays ZERO_PAD. The next beat with in_sof=1 and every beat after it uses REPLICATE.
- Backpressure: stream pixels 1..20 while out_ready toggles pseudo-randomly → output sequence is exactly 1..20. in_ready=0 occurs only while the skid is full. At most 2 beats are in flight.
- Blanking and sideband: in_de=0 with pixel 8'hFF in mode 1 → R/G/B=0. hsync, vsync and sof patterns appear with 1-cycle latency, aligned to their pixels.
- Reset: assert rst_n=0 while stalled with both registers full → outputs go to their reset values immediately. After release, in_ready=1 after the first edge, no stale beat emerges, and the mode is ZERO_PAD.
- Parameter sweep at OUT_W=8 with R_IN_W=5, G_IN_W=6, B_IN_W=5: R in=5'b10011 under REPLICATE → 8'b10011100. Inputs all-ones → 8'hFF in REPLICATE mode.

Source files
------------

// File: rtl/rgb_stream_remap_if.sv
// Stream bundle for rgb_stream_remap: packed low-depth pixels in, expanded DAC channels out.
// The slave modport is the remapper's view; the master modport is the driver/sink side.
interface rgb_stream_remap_if #(
  parameter int R_IN_W = 3,
  parameter int G_IN_W = 3,
  parameter int B_IN_W = 2,
  parameter int OUT_W  = 4
);
  localparam int PIX_W = R_IN_W + G_IN_W + B_IN_W;

  logic [1:0]       mode;
  logic [PIX_W-1:0] in_pixel;
  logic             in_hsync;
  logic             in_vsync;
  logic             in_de;
  logic             in_sof;
  logic             in_valid;
  logic             in_ready;

  logic [OUT_W-1:0] R;
  logic [OUT_W-1:0] G;
  logic [OUT_W-1:0] B;
  logic             out_hsync;
  logic             out_vsync;
  logic             out_de;
  logic             out_sof;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  mode, in_pixel, in_hsync, in_vsync, in_de, in_sof, in_valid, out_ready,
    output in_ready, R, G, B, out_hsync, out_vsync, out_de, out_sof, out_valid
  );

  modport master (
    output mode, in_pixel, in_hsync, in_vsync, in_de, in_sof, in_valid, out_ready,
    input  in_ready, R, G, B, out_hsync, out_vsync, out_de, out_sof, out_valid
  );
endinterface

// File: rtl/rgb_stream_remap.sv
// Colour expander from packed low-depth RGB to OUT_W-bit DAC channels, with frame-synchronous
// mode switching and a registered valid/ready stage backed by a one-beat skid register.
module rgb_stream_remap #(
  parameter int R_IN_W = 3,
  parameter int G_IN_W = 3,
  parameter int B_IN_W = 2,
  parameter int OUT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  rgb_stream_remap_if.slave bus
);
  localparam int PIX_W = R_IN_W + G_IN_W + B_IN_W;

  typedef enum logic [1:0] {
    MODE_ZERO_PAD  = 2'd0,
    MODE_SHIFT     = 2'd1,
    MODE_REPLICATE = 2'd2,
    MODE_BLANK     = 2'd3
  } mode_e;

  typedef struct packed {
    logic [OUT_W-1:0] r;
    logic [OUT_W-1:0] g;
    logic [OUT_W-1:0] b;
    logic             hsync;
    logic             vsync;
    logic             de;
    logic             sof;
  } beat_t;

  if (OUT_W < 1 || OUT_W > 8) begin : g_bad_out_w
    $error("rgb_stream_remap: OUT_W must lie in 1..8");
  end
  if (R_IN_W < 1 || R_IN_W > OUT_W) begin : g_bad_r_w
    $error("rgb_stream_remap: R_IN_W must lie in 1..OUT_W");
  end
  if (G_IN_W < 1 || G_IN_W > OUT_W) begin : g_bad_g_w
    $error("rgb_stream_remap: G_IN_W must lie in 1..OUT_W");
  end
  if (B_IN_W < 1 || B_IN_W > OUT_W) begin : g_bad_b_w
    $error("rgb_stream_remap: B_IN_W must lie in 1..OUT_W");
  end

  // Replication stacks eight copies of v (at least 8 bits) and keeps the top OUT_W of them.
  function automatic logic [OUT_W-1:0] expandChannel(input logic [7:0] v, input int w,
                                                     input mode_e m);
    logic [OUT_W-1:0] res;
    logic [15:0]      sh;
    logic [63:0]      rep;
    res = '0;
    sh  = '0;
    rep = '0;
    case (m)
      MODE_ZERO_PAD: res = v[OUT_W-1:0];
      MODE_SHIFT: begin
        sh  = 16'(v) << (OUT_W - w);
        res = sh[OUT_W-1:0];
      end
      MODE_REPLICATE: begin
        for (int k = 0; k < 8; k++) begin
          rep = (rep << w) | 64'(v);
        end
        res = OUT_W'(rep >> (8 * w - OUT_W));
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  logic [R_IN_W-1:0] w_r_in;
  logic [G_IN_W-1:0] w_g_in;
  logic [B_IN_W-1:0] w_b_in;
  mode_e             w_conv_mode;
  mode_e             w_mode_nxt;
  mode_e             r_mode;
  beat_t             w_new;
  beat_t             w_out_nxt;
  beat_t             w_skid_nxt;
  beat_t             r_out;
  beat_t             r_skid;
  logic              w_out_valid_nxt;
  logic              w_skid_valid_nxt;
  logic              r_out_valid;
  logic              r_skid_valid;
  logic              r_in_ready;
  logic              w_accept;
  logic              w_consume;

  assign w_r_in = bus.in_pixel[PIX_W-1 -: R_IN_W];
  assign w_g_in = bus.in_pixel[B_IN_W +: G_IN_W];
  assign w_b_in = bus.in_pixel[B_IN_W-1:0];

  assign w_accept  = bus.in_valid && r_in_ready;
  assign w_consume = r_out_valid && bus.out_ready;

  // A start-of-frame beat is converted with the mode it is about to load, not the old one.
  assign w_conv_mode = bus.in_sof ? mode_e'(bus.mode) : r_mode;

  always_comb begin
    w_new       = '0;
    w_new.hsync = bus.in_hsync;
    w_new.vsync = bus.in_vsync;
    w_new.de    = bus.in_de;
    w_new.sof   = bus.in_sof;
    if (bus.in_de) begin
      w_new.r = expandChannel(8'(w_r_in), R_IN_W, w_conv_mode);
      w_new.g = expandChannel(8'(w_g_in), G_IN_W, w_conv_mode);
      w_new.b = expandChannel(8'(w_b_in), B_IN_W, w_conv_mode);
    end
  end

  // Accepts only happen with the skid empty, so accept and skid-to-output never coincide.
  always_comb begin
    w_mode_nxt       = r_mode;
    w_out_valid_nxt  = r_out_valid;
    w_out_nxt        = r_out;
    w_skid_valid_nxt = r_skid_valid;
    w_skid_nxt       = r_skid;
    if (w_accept && bus.in_sof) begin
      w_mode_nxt = mode_e'(bus.mode);
    end
    if (w_accept) begin
      if (!r_out_valid || bus.out_ready) begin
        w_out_valid_nxt = 1'b1;
        w_out_nxt       = w_new;
      end else begin
        w_skid_valid_nxt = 1'b1;
        w_skid_nxt       = w_new;
      end
    end else if (w_consume) begin
      if (r_skid_valid) begin
        w_out_nxt        = r_skid;
        w_skid_valid_nxt = 1'b0;
      end else begin
        w_out_valid_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode       <= MODE_ZERO_PAD;
      r_out_valid  <= 1'b0;
      r_out        <= '0;
      r_skid_valid <= 1'b0;
      r_skid       <= '0;
      r_in_ready   <= 1'b0;
    end else begin
      r_mode       <= w_mode_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_out        <= w_out_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_skid       <= w_skid_nxt;
      r_in_ready   <= !w_skid_valid_nxt;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.R         = r_out.r;
  assign bus.G         = r_out.g;
  assign bus.B         = r_out.b;
  assign bus.out_hsync = r_out.hsync;
  assign bus.out_vsync = r_out.vsync;
  assign bus.out_de    = r_out.de;
  assign bus.out_sof   = r_out.sof;
endmodule

// File: tb/tb_rgb_stream_remap.sv
// Self-checking bench for rgb_stream_remap: vector table, hand-written corner sequences and a
// randomized backpressure run scored against an arithmetic reference model.
module tb_rgb_stream_remap;
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    logic       hs;
    logic       vs;
    logic       de;
    logic       sof;
  } beat_t;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] pixel;
    logic       de;
    logic       hs;
    logic       vs;
    logic       sof;
    logic [3:0] expR;
    logic [3:0] expG;
    logic [3:0] expB;
  } vec_t;

  logic  clk;
  logic  rst_n;
  int    passCount;
  int    checkCount;
  int    modelMode;
  beat_t sb[$];
  vec_t  vecs[10];
  vec_t  postRst;

  rgb_stream_remap_if #(.R_IN_W(3), .G_IN_W(3), .B_IN_W(2), .OUT_W(4)) bus ();
  rgb_stream_remap_if #(.R_IN_W(5), .G_IN_W(6), .B_IN_W(5), .OUT_W(8)) bus8 ();

  rgb_stream_remap #(.R_IN_W(3), .G_IN_W(3), .B_IN_W(2), .OUT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  rgb_stream_remap #(.R_IN_W(5), .G_IN_W(6), .B_IN_W(5), .OUT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
  endtask

  // Channel expansion from the rules: padding, scaling by a power of two, or repeating the code.
  function automatic int expandRef(input int v, input int w, input int ow, input int m);
    int acc;
    int bits;
    if (m == 3) return 0;
    if (m == 0) return v;
    if (m == 1) return v * (1 << (ow - w));
    acc  = 0;
    bits = 0;
    while (bits < ow) begin
      acc  = acc * (1 << w) + v;
      bits = bits + w;
    end
    return acc >> (bits - ow);
  endfunction

  function automatic beat_t refBeat(input logic [7:0] pixel, input int m, input logic de,
                                    input logic hs, input logic vs, input logic sof);
    beat_t bt;
    bt     = '0;
    bt.hs  = hs;
    bt.vs  = vs;
    bt.de  = de;
    bt.sof = sof;
    if (de) begin
      bt.r = 4'(expandRef(int'(pixel[7:5]), 3, 4, m));
      bt.g = 4'(expandRef(int'(pixel[4:2]), 3, 4, m));
      bt.b = 4'(expandRef(int'(pixel[1:0]), 2, 4, m));
    end
    return bt;
  endfunction

  function automatic beat_t currentBeat();
    return {bus.R, bus.G, bus.B, bus.out_hsync, bus.out_vsync, bus.out_de, bus.out_sof};
  endfunction

  task automatic checkResetState(input string name);
    checkOutput({name, "_outValid"}, 32'(bus.out_valid), 32'd0);
    checkOutput({name, "_inReady"}, 32'(bus.in_ready), 32'd0);
    checkOutput({name, "_beat"}, 32'(currentBeat()), 32'd0);
  endtask

  task automatic applyStimulus(input string name, input vec_t v);
    beat_t expBeat;
    expBeat = {v.expR, v.expG, v.expB, v.hs, v.vs, v.de, v.sof};
    @(negedge clk);
    bus.mode      = v.mode;
    bus.in_pixel  = v.pixel;
    bus.in_de     = v.de;
    bus.in_hsync  = v.hs;
    bus.in_vsync  = v.vs;
    bus.in_sof    = v.sof;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    checkOutput({name, "_inReady"}, 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checkOutput({name, "_outValid"}, 32'(bus.out_valid), 32'd1);
    checkOutput({name, "_beat"}, 32'(currentBeat()), 32'(expBeat));
  endtask

  task automatic applyStimulus8(input string name, input logic [1:0] mode,
                                input logic [15:0] pixel, input logic sof,
                                input logic [23:0] expRgb);
    @(negedge clk);
    bus8.mode      = mode;
    bus8.in_pixel  = pixel;
    bus8.in_de     = 1'b1;
    bus8.in_sof    = sof;
    bus8.in_valid  = 1'b1;
    bus8.out_ready = 1'b1;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    checkOutput({name, "_outValid"}, 32'(bus8.out_valid), 32'd1);
    checkOutput({name, "_rgb"}, 32'({bus8.R, bus8.G, bus8.B}), 32'(expRgb));
  endtask

  task automatic resetWhileStalled();
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.mode      = 2'd2;
    bus.in_pixel  = 8'hAE;
    bus.in_de     = 1'b1;
    bus.in_hsync  = 1'b1;
    bus.in_vsync  = 1'b1;
    bus.in_sof    = 1'b1;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    bus.in_sof = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    checkOutput("stall_inReadyLow", 32'(bus.in_ready), 32'd0);
    checkOutput("stall_outValid", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkResetState("midStreamRst");
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("postRst_inReady", 32'(bus.in_ready), 32'd1);
    checkOutput("postRst_noStale", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    checkOutput("postRst_noStale2", 32'(bus.out_valid), 32'd0);
    applyStimulus("postRst_modeZero", postRst);
  endtask

  task automatic runRandom(input int nBeats);
    int         sent;
    int         recv;
    int         cycles;
    beat_t      act;
    beat_t      held;
    logic       wasHeld;
    beat_t      expBeat;
    sent    = 0;
    recv    = 0;
    cycles  = 0;
    wasHeld = 1'b0;
    held    = '0;
    sb.delete();
    while (recv < nBeats && cycles < 2000) begin
      @(negedge clk);
      cycles++;
      act = currentBeat();
      checkOutput("rnd_inReadyVsSkid", 32'(bus.in_ready), 32'(sb.size() < 2));
      checkOutput("rnd_outValidVsFill", 32'(bus.out_valid), 32'(sb.size() > 0));
      if (wasHeld) checkOutput("rnd_holdStable", 32'(act), 32'(held));
      bus.out_ready = ($urandom_range(0, 2) != 0);
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() > 0) begin
          expBeat = sb.pop_front();
          checkOutput($sformatf("rnd_beat%0d", recv), 32'(act), 32'(expBeat));
        end
        recv++;
      end
      wasHeld      = bus.out_valid && !bus.out_ready;
      held         = act;
      bus.in_valid = (sent < nBeats) && ($urandom_range(0, 3) != 0);
      bus.in_pixel = (sent < 20) ? 8'(sent + 1) : 8'($urandom);
      bus.mode     = 2'($urandom);
      bus.in_sof   = ($urandom_range(0, 5) == 0);
      bus.in_de    = ($urandom_range(0, 7) != 0);
      bus.in_hsync = 1'($urandom);
      bus.in_vsync = 1'($urandom);
      if (bus.in_valid && bus.in_ready) begin
        if (bus.in_sof) modelMode = int'(bus.mode);
        sb.push_back(refBeat(bus.in_pixel, modelMode, bus.in_de, bus.in_hsync,
                             bus.in_vsync, bus.in_sof));
        sent++;
      end
    end
    bus.in_valid = 1'b0;
    checkOutput("rnd_allReceived", 32'(recv), 32'(nBeats));
    checkOutput("rnd_nothingLeft", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    passCount  = 0;
    checkCount = 0;
    modelMode  = 0;

    vecs[0] = '{2'd0, 8'hAE, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0101, 4'b0011, 4'b0010};
    vecs[1] = '{2'd1, 8'hAE, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1010, 4'b0110, 4'b1000};
    vecs[2] = '{2'd2, 8'hAE, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1011, 4'b0110, 4'b1010};
    vecs[3] = '{2'd3, 8'hAE, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000};
    vecs[4] = '{2'd1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000};
    vecs[5] = '{2'd0, 8'hAE, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0101, 4'b0011, 4'b0010};
    vecs[6] = '{2'd2, 8'hAE, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0101, 4'b0011, 4'b0010};
    vecs[7] = '{2'd2, 8'hAE, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1011, 4'b0110, 4'b1010};
    vecs[8] = '{2'd0, 8'hAE, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1011, 4'b0110, 4'b1010};
    vecs[9] = '{2'd1, 8'hE1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1111, 4'b0000, 4'b0101};
    postRst = '{2'd2, 8'hAE, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0101, 4'b0011, 4'b0010};

    bus.mode       = 2'd0;
    bus.in_pixel   = '0;
    bus.in_hsync   = 1'b0;
    bus.in_vsync   = 1'b0;
    bus.in_de      = 1'b0;
    bus.in_sof     = 1'b0;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b1;
    bus8.mode      = 2'd0;
    bus8.in_pixel  = '0;
    bus8.in_hsync  = 1'b0;
    bus8.in_vsync  = 1'b0;
    bus8.in_de     = 1'b0;
    bus8.in_sof    = 1'b0;
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;

    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checkResetState("initRst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("inReadyBeforeFirstEdge", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    checkOutput("inReadyAfterFirstEdge", 32'(bus.in_ready), 32'd1);
    checkOutput("dut8_inReady", 32'(bus8.in_ready), 32'd1);

    for (int i = 0; i < 10; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i]);
    end

    applyStimulus8("w8_replicate", 2'd2, {5'b10011, 6'b101010, 5'b00001}, 1'b1,
                   {8'b10011100, 8'hAA, 8'h08});
    applyStimulus8("w8_allOnes", 2'd2, 16'hFFFF, 1'b0, {8'hFF, 8'hFF, 8'hFF});
    applyStimulus8("w8_shift", 2'd1, {5'b10011, 6'b101010, 5'b00001}, 1'b1,
                   {8'h98, 8'hA8, 8'h08});
    applyStimulus8("w8_zeroPad", 2'd0, {5'b10011, 6'b101010, 5'b00001}, 1'b1,
                   {8'h13, 8'h2A, 8'h01});

    resetWhileStalled();

    modelMode = 0;
    @(negedge clk);
    runRandom(60);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
